// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host-transmit constants: FSM state encodings, common keyboard
// commands and frame geometry.
package ps2_host_tx_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_SHIFT     = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises one raw PS/2 line, rejects glitches shorter than FILTER_LEN
// samples and flags filtered 1->0 transitions with a one-cycle pulse.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic line_raw,
    output logic level,
    output logic fall
);

    localparam int CNT_W = $clog2(FILTER_LEN) + 1;

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             fall_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            fall_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= line_raw;
            sync2_reg <= sync1_reg;
            fall_reg  <= 1'b0;
            // Any sample agreeing with the current level restarts the run.
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
                level_reg <= sync2_reg;
                fall_reg  <= level_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out one
// byte on device clock falling edges, then check the device ACK bit.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int PHASE_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX) + 1;
    localparam int TO_W      = $clog2(TIMEOUT_CYCLES) + 1;

    logic               clk_level;
    logic               clk_fall;
    logic               data_level;
    logic               data_fall_unused;

    logic [2:0]         state_reg;
    logic [7:0]         shift_reg;
    logic               parity_reg;
    logic [3:0]         edge_cnt_reg;
    logic [PHASE_W-1:0] phase_cnt_reg;
    logic [TO_W-1:0]    to_cnt_reg;
    logic               data_oe_reg;
    logic               ack_failed_reg;
    logic               done_reg;
    logic               ack_err_reg;
    logic               timeout_err_reg;
    logic               timeout_hit;
    logic               watch_active;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .line_raw (ps2_clk_in),
        .level    (clk_level),
        .fall     (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .line_raw (ps2_data_in),
        .level    (data_level),
        .fall     (data_fall_unused)
    );

    assign watch_active = (state_reg == ST_SHIFT) || (state_reg == ST_ACK) ||
                          (state_reg == ST_WAIT_IDLE);
    assign timeout_hit  = (to_cnt_reg == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg       <= ST_IDLE;
            shift_reg       <= '0;
            parity_reg      <= 1'b0;
            edge_cnt_reg    <= '0;
            phase_cnt_reg   <= '0;
            to_cnt_reg      <= '0;
            data_oe_reg     <= 1'b0;
            ack_failed_reg  <= 1'b0;
            done_reg        <= 1'b0;
            ack_err_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            done_reg        <= 1'b0;
            ack_err_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;

            // Saturating watchdog on the device clock, cleared by every edge.
            if (clk_fall)
                to_cnt_reg <= '0;
            else if (!timeout_hit)
                to_cnt_reg <= to_cnt_reg + 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (tx_valid) begin
                        shift_reg      <= tx_data;
                        parity_reg     <= odd_parity(tx_data);
                        phase_cnt_reg  <= '0;
                        ack_failed_reg <= 1'b0;
                        state_reg      <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (phase_cnt_reg == PHASE_W'(INHIBIT_CYCLES - 1)) begin
                        phase_cnt_reg <= '0;
                        state_reg     <= ST_START;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg + 1'b1;
                    end
                end
                ST_START: begin
                    if (phase_cnt_reg == PHASE_W'(START_CYCLES - 1)) begin
                        edge_cnt_reg <= '0;
                        to_cnt_reg   <= '0;
                        data_oe_reg  <= 1'b1;
                        state_reg    <= ST_SHIFT;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (watch_active && timeout_hit) begin
                        data_oe_reg     <= 1'b0;
                        timeout_err_reg <= 1'b1;
                        state_reg       <= ST_IDLE;
                    end else if (state_reg == ST_SHIFT) begin
                        if (clk_fall) begin
                            edge_cnt_reg <= edge_cnt_reg + 1'b1;
                            if (edge_cnt_reg < 4'(PS2_FRAME_BITS - 3)) begin
                                data_oe_reg <= ~shift_reg[0];
                                shift_reg   <= {1'b0, shift_reg[7:1]};
                            end else if (edge_cnt_reg == 4'(PS2_FRAME_BITS - 3)) begin
                                data_oe_reg <= ~parity_reg;
                            end else begin
                                data_oe_reg <= 1'b0;
                                state_reg   <= ST_ACK;
                            end
                        end
                    end else if (state_reg == ST_ACK) begin
                        if (clk_fall) begin
                            if (data_level) begin
                                ack_err_reg    <= 1'b1;
                                ack_failed_reg <= 1'b1;
                            end
                            state_reg <= ST_WAIT_IDLE;
                        end
                    end else if (state_reg == ST_WAIT_IDLE) begin
                        if (clk_level && data_level) begin
                            done_reg  <= ~ack_failed_reg;
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Line drives decode straight from state so reset releases them at once.
    assign ps2_clk_oe  = (state_reg == ST_INHIBIT) || (state_reg == ST_START);
    assign ps2_data_oe = (state_reg == ST_START) || ((state_reg == ST_SHIFT) && data_oe_reg);
    assign tx_ready    = (state_reg == ST_IDLE);
    assign busy        = ~tx_ready;
    assign rx_inhibit  = busy;
    assign done        = done_reg;
    assign ack_err     = ack_err_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the write direction paired with the existing keyboard receiver.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset, using the open-drain clock/data request-to-send protocol. It then checks the device ACK bit.
- Sits in the GPIO block beside the receiver. An AHB register write loads the byte; done/error flags feed the PS/2 interrupt path.
- Asserts rx_inhibit while active so the receiver ignores host-generated traffic.

Parameters:
INHIBIT_CYCLES, 5000, HCLK cycles the host holds ps2 clock low before the request (≥100 us at 50 MHz)
START_CYCLES, 16, HCLK cycles with clock and data both held low before clock release
TIMEOUT_CYCLES, 1000000, maximum HCLK cycles allowed between consecutive device clock falling edges (and before the first one)
FILTER_LEN, 8, consecutive equal samples needed to accept a line level change

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
tx_data  in  8  byte to send
tx_valid  in  1  request; accepted when tx_valid & tx_ready
tx_ready  out  1  high only in IDLE
busy  out  1  high in every state except IDLE
rx_inhibit  out  1  equals busy; receiver discards bits while high
ps2_clk_in  in  1  raw PS/2 clock line (asynchronous)
ps2_data_in  in  1  raw PS/2 data line (asynchronous)
ps2_clk_oe  out  1  1 = pull clock low; 0 = release
ps2_data_oe  out  1  1 = pull data low; 0 = release
done  out  1  one-cycle pulse: transfer finished with ACK received
ack_err  out  1  one-cycle pulse: ACK bit sampled high
timeout_err  out  1  one-cycle pulse: device clock timeout, transfer aborted

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs 0 except tx_ready=1. Lines released immediately, including mid-transfer. Filtered levels reset to 1.
- Input conditioning: each raw line passes a 2-flop synchronizer, then the glitch filter. The filtered level changes only after FILTER_LEN consecutive agreeing samples. A falling edge is filtered 1→0, one HCLK pulse wide.
- Acceptance: on tx_valid & tx_ready, latch tx_data and compute parity = ~^tx_data (odd parity). Enter INHIBIT on the next cycle.
- Host has priority: a transfer starts even if the device is mid-transmission.
- tx_valid while busy is ignored; nothing is queued.
- INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to START.
- START: clk_oe=1, data_oe=1 (start bit 0) for START_CYCLES cycles, then go to SHIFT.
- SHIFT: clk_oe=0. data_oe stays 1 until the first falling edge. edge_cnt starts at 0 and increments on each falling edge. For edge k:
  - k=1..8: drive data bit k-1, LSB first; data_oe = ~bit.
  - k=9: drive parity.
  - k=10: data_oe=0 (stop bit, released); go to ACK.
- ACK: on the next falling edge, sample filtered data.
  - Data 0: go to WAIT_IDLE.
  - Data 1: pulse ack_err and go to WAIT_IDLE (the line must still settle).
- WAIT_IDLE: both lines released. When filtered clk=1 and data=1, go to IDLE.
  - Pulse done in that same cycle unless ack_err was already pulsed for this transfer.
- Timeout: a counter resets on entry to SHIFT and on every falling edge. It is active in SHIFT, ACK and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES: release both lines, pulse timeout_err, go to IDLE. No done pulse.
- Exactly one of done, ack_err or timeout_err pulses per accepted byte.
- Counter widths use $clog2 of the corresponding parameter plus 1. Counters saturate and never wrap.

Decomposition:
- Shared constants header, alongside the existing const header: state encodings (IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE), PS/2 command constants (0xED, 0xF4, 0xFF), and the PS/2 bit count of 11.
- One sub-module, ps2_line_filter: synchronizer, glitch filter and falling-edge pulse, parameter FILTER_LEN. Instantiated twice, once per line.

Test Plan:
- Send 0xED with a device model clocking at 12 kHz and ACKing → data bits 1,0,1,1,0,1,1,1 then parity 1 and stop 1. One done pulse, tx_ready back to 1.
- Send 0x00 → parity bit 1. Send 0x01 → parity bit 0. Send 0xFF → parity bit 1. Verify each with the device sampling on the rising edge.
- Device leaves data high on the 11th clock → ack_err pulses once; done stays 0; module returns to IDLE once lines are high.
- Device never clocks after START → timeout_err after TIMEOUT_CYCLES. Both oe outputs 0 and busy 0 on the following cycle.
- Assert HRESETn low during bit 4 of SHIFT → clk_oe=0 and data_oe=0 immediately. After release, a new 0xF4 transfers correctly.
- Inject 3-cycle clock glitches (below FILTER_LEN) mid-byte, and tx_valid pulses while busy → no extra edges counted, no second transfer, byte correct.
